// File: rtl/debounce_edge.sv
// Input conditioner: synchronizer chain plus debounce FSM producing a clean level,
// one-cycle rise/fall strobes and a wrapping count of accepted rising edges.
module debounce_edge #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4,
   parameter int CNT_W       = 8,
   parameter int EVT_W       = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Din,
   output logic             Dout,
   output logic             Rise,
   output logic             Fall,
   output logic             Busy,
   output logic [EVT_W-1:0] Evt_Count
);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHK_HI    = 2'd1,
      STABLE_HI = 2'd2,
      CHK_LO    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [EVT_W-1:0]       evt_q, evt_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   dout_q, dout_d;
   logic                   busy_q, busy_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], Din};
      state_d = state_q;
      cnt_d   = cnt_q;
      evt_d   = evt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (s) begin
               if (DB_CYCLES == 1) begin
                  state_d = STABLE_HI;
                  rise_d  = 1'b1;
                  evt_d   = evt_q + 1'b1;
               end else begin
                  state_d = CHK_HI;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         CHK_HI: begin
            if (!s) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               rise_d  = 1'b1;
               evt_d   = evt_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STABLE_HI: begin
            if (!s) begin
               if (DB_CYCLES == 1) begin
                  state_d = STABLE_LO;
                  fall_d  = 1'b1;
               end else begin
                  state_d = CHK_LO;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         CHK_LO: begin
            if (s) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
      // Level and busy are decoded from the next state so they land in flops.
      dout_d = (state_d == STABLE_HI) || (state_d == CHK_LO);
      busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync_q  <= '0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         evt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         dout_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         evt_q   <= evt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
      end
   end

   assign Dout      = dout_q;
   assign Rise      = rise_q;
   assign Fall      = fall_q;
   assign Busy      = busy_q;
   assign Evt_Count = evt_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: window-based reference model checked every cycle,
// plus directed sequences with hand-computed edge-by-edge expectations.
module tb_debounce_edge;

   localparam int SYNC  = 2;
   localparam int DB    = 4;
   localparam int EVT_W = 8;

   logic             clk = 1'b0;
   logic             Reset = 1'b1;
   logic             Din = 1'b0;
   logic             Dout, Rise, Fall, Busy;
   logic [EVT_W-1:0] Evt_Count;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   debounce_edge #(
      .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .CNT_W(8), .EVT_W(EVT_W)
   ) dut (
      .Clk(clk), .Reset(Reset), .Din(Din), .Dout(Dout), .Rise(Rise),
      .Fall(Fall), .Busy(Busy), .Evt_Count(Evt_Count)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: every Din sample seen since reset, oldest first.
   bit               hist[$];
   logic             m_dout = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;
   logic [EVT_W-1:0] m_evt = '0;

   function automatic bit s_at(input int idx);
      if (idx < 0) return 1'b0;
      return hist[idx];
   endfunction

   // The level flips once the last DB synchronized samples all disagree with it.
   always @(posedge clk or posedge Reset) begin
      if (Reset) begin
         hist.delete();
         m_dout <= 1'b0;
         m_rise <= 1'b0;
         m_fall <= 1'b0;
         m_busy <= 1'b0;
         m_evt  <= '0;
      end else begin
         int  n;
         bit  all_diff;
         bit  nd;
         hist.push_back(Din);
         if (hist.size() > 64) void'(hist.pop_front());
         n = hist.size();
         nd = m_dout;
         all_diff = 1'b1;
         for (int i = 0; i < DB; i++)
            if (s_at(n - 1 - SYNC - i) == nd) all_diff = 1'b0;
         m_rise <= 1'b0;
         m_fall <= 1'b0;
         if (all_diff) begin
            nd = !nd;
            if (nd) begin
               m_rise <= 1'b1;
               m_evt  <= m_evt + 1'b1;
            end else begin
               m_fall <= 1'b1;
            end
         end
         m_dout <= nd;
         m_busy <= (s_at(n - 1 - SYNC) != nd);
      end
   end

   always @(negedge clk) begin
      if (!Reset && chk_en) begin
         chk("model_dout", {31'b0, Dout}, {31'b0, m_dout});
         chk("model_rise", {31'b0, Rise}, {31'b0, m_rise});
         chk("model_fall", {31'b0, Fall}, {31'b0, m_fall});
         chk("model_busy", {31'b0, Busy}, {31'b0, m_busy});
         chk("model_evt", {24'b0, Evt_Count}, {24'b0, m_evt});
         chk("rise_fall_excl", {31'b0, Rise & Fall}, 32'd0);
      end
   end

   task automatic hold(input logic v, input int cycles);
      Din = v;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      int rises;
      // Reset with Din low
      #1;
      chk("rst_dout", {31'b0, Dout}, 32'd0);
      chk("rst_busy", {31'b0, Busy}, 32'd0);
      chk("rst_evt", {24'b0, Evt_Count}, 32'd0);
      repeat (3) @(negedge clk);
      Reset = 1'b0;
      chk_en = 1'b1;
      rises = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (Rise || Fall) rises++;
      end
      chk("idle_strobes", rises, 0);
      chk("idle_dout", {31'b0, Dout}, 32'd0);

      // Din 0->1 held: edge-by-edge latency
      Din = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 2) chk("e2_busy", {31'b0, Busy}, 32'd0);
         if (k == 3) chk("e3_busy", {31'b0, Busy}, 32'd1);
         if (k == 5) chk("e5_dout", {31'b0, Dout}, 32'd0);
         if (k == 6) begin
            chk("e6_dout", {31'b0, Dout}, 32'd1);
            chk("e6_rise", {31'b0, Rise}, 32'd1);
         end
         if (k == 7) begin
            chk("e7_rise", {31'b0, Rise}, 32'd0);
            chk("e7_evt", {24'b0, Evt_Count}, 32'd1);
         end
      end

      // Din 1->0 held: fall on edge 6
      Din = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 5) chk("f5_fall", {31'b0, Fall}, 32'd0);
         if (k == 6) begin
            chk("f6_fall", {31'b0, Fall}, 32'd1);
            chk("f6_dout", {31'b0, Dout}, 32'd0);
         end
         if (k == 7) begin
            chk("f7_fall", {31'b0, Fall}, 32'd0);
            chk("f7_evt", {24'b0, Evt_Count}, 32'd1);
         end
      end

      // Three-cycle pulse is rejected
      hold(1'b1, 3);
      hold(1'b0, 10);
      chk("pulse_dout", {31'b0, Dout}, 32'd0);
      chk("pulse_busy", {31'b0, Busy}, 32'd0);
      chk("pulse_evt", {24'b0, Evt_Count}, 32'd1);

      // Bounce 1,0,1,1,1,1 then hold: single rise 6 edges after the last 0->1
      hold(1'b1, 1);
      hold(1'b0, 1);
      Din = 1'b1;
      rises = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 5) chk("b5_dout", {31'b0, Dout}, 32'd0);
         if (k == 6) chk("b6_rise", {31'b0, Rise}, 32'd1);
         if (Rise) rises++;
      end
      chk("bounce_one_rise", rises, 1);
      chk("bounce_evt", {24'b0, Evt_Count}, 32'd2);
      hold(1'b0, 8);

      // 254 more rises bring the count to 256, which wraps to 0
      for (int k = 0; k < 254; k++) begin
         hold(1'b1, 7);
         hold(1'b0, 7);
      end
      chk("wrap_evt", {24'b0, Evt_Count}, 32'd0);

      // Randomized run lengths
      for (int k = 0; k < 600; k++)
         hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
      hold(1'b0, 10);

      // Reset mid-qualification with counter at 2
      Din = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_busy", {31'b0, Busy}, 32'd1);
      #2 Reset = 1'b1;
      #1;
      chk("mid_rst_dout", {31'b0, Dout}, 32'd0);
      chk("mid_rst_busy", {31'b0, Busy}, 32'd0);
      chk("mid_rst_evt", {24'b0, Evt_Count}, 32'd0);
      Din = 1'b0;
      @(negedge clk);
      Reset = 1'b0;
      rises = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (Rise) rises++;
      end
      chk("mid_no_rise", rises, 0);

      // Din held high through reset release
      Reset = 1'b1;
      Din = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 5) chk("r5_rise", {31'b0, Rise}, 32'd0);
         if (k == 6) chk("r6_rise", {31'b0, Rise}, 32'd1);
      end
      hold(1'b1, 5);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Input-conditioning stage that sits directly upstream of the level-sensitive D latch.
- Takes a raw asynchronous input (switch or button) and passes it through a synchronizer and a debounce state machine.
- Outputs a clean level `Dout`, which feeds the latch's D input.
- Also outputs one-cycle `Rise`/`Fall` strobes and a wrapping count of accepted rising edges, for use as latch-enable and for downstream status.

Parameters:
- `SYNC_STAGES`, default 2: number of synchronizer flops. Legal range is 2 or more.
- `DB_CYCLES`, default 4: number of consecutive differing synchronized samples required to accept a new level. Legal range is 1 to 2^CNT_W-1.
- `CNT_W`, default 8: width of the debounce counter.
- `EVT_W`, default 8: width of the rising-edge event counter.

Ports:
- `Clk`  input  1  single rising-edge clock.
- `Reset`  input  1  asynchronous, active-high reset.
- `Din`  input  1  raw asynchronous input; may glitch.
- `Dout`  output  1  debounced level; drives the downstream latch D.
- `Rise`  output  1  one-cycle pulse when `Dout` goes 0->1.
- `Fall`  output  1  one-cycle pulse when `Dout` goes 1->0.
- `Busy`  output  1  high while a candidate level change is being qualified.
- `Evt_Count`  output  EVT_W  number of accepted rising edges, modulo 2^EVT_W.

Behaviour:
- Reset (asynchronous, active-high, effective immediately and at any point):
  - All synchronizer flops = 0; debounce counter = 0; state = STABLE_LO.
  - `Dout`=0, `Rise`=0, `Fall`=0, `Busy`=0, `Evt_Count`=0.
  - Reset asserted mid-qualification discards the partial count; no strobe is emitted.
- Synchronizer: `Din` -> a chain of SYNC_STAGES flops; `s` denotes the last stage. Nothing other than the first flop samples `Din`.
- FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
  - `Dout`=1 in STABLE_HI and CHK_LO; `Dout`=0 otherwise.
  - `Busy`=1 in CHK_HI and CHK_LO.
  - All outputs are registered; no combinational path from `Din`.
- Transitions, evaluated each rising edge of `Clk`:
  - STABLE_LO:
    - `s`=1 and DB_CYCLES=1 -> STABLE_HI, assert `Rise`.
    - `s`=1 otherwise -> CHK_HI, counter=1.
    - `s`=0 -> stay.
  - CHK_HI:
    - `s`=0 -> STABLE_LO, counter=0 (glitch rejected, no strobe).
    - `s`=1 and counter==DB_CYCLES-1 -> STABLE_HI, counter=0, `Rise`=1, `Evt_Count` += 1.
    - `s`=1 otherwise -> counter += 1.
  - STABLE_HI and CHK_LO: mirror images of the above with `s` inverted; commit asserts `Fall`. `Evt_Count` is unchanged on falls.
- Latency: `Dout` changes on the (SYNC_STAGES+DB_CYCLES)-th rising edge counting the first edge that samples the new `Din` value, given `Din` is held stable. Defaults: 6 edges.
- Strobes:
  - `Rise`/`Fall` are high for exactly one cycle, coincident with the `Dout` update edge.
  - `Rise` and `Fall` are never high together.
  - Back-to-back opposite changes are separated by at least DB_CYCLES cycles.
- `Evt_Count`: wraps from 2^EVT_W-1 to 0 with no saturation and no flag.
- Debounce counter: never exceeds DB_CYCLES-1; reset to 0 on every commit and on every rejection.
- Boundary cases:
  - A pulse on `s` shorter than DB_CYCLES cycles: `Dout` and the strobes do not change; FSM returns to the stable state.
  - Any bounce during CHK restarts qualification from zero.
  - `Din` held high through reset release: `Rise` fires SYNC_STAGES+DB_CYCLES edges after deassertion.

Test Plan (defaults: SYNC_STAGES=2, DB_CYCLES=4, EVT_W=8):
- Reset with `Din`=0, then release -> `Dout`=0, `Busy`=0, `Evt_Count`=0; no strobes for 20 cycles.
- Set `Din` 0->1 and hold -> `Busy` rises on edge 3; `Dout`=1 and `Rise`=1 on edge 6; `Rise`=0 on edge 7; `Evt_Count`=1.
- From STABLE_LO, pulse `Din` high for 3 cycles then low -> `Dout` stays 0, no `Rise`, `Busy` returns to 0, `Evt_Count` unchanged.
- `Din` bounces 1,0,1,1,1,1 (one value per cycle) -> the counter restarts after the 0; `Rise` fires 6 edges after the final 0->1 transition; exactly one `Rise`.
- From STABLE_HI, drop `Din` to 0 -> `Fall` pulses for 1 cycle at edge 6; `Dout`=0; `Evt_Count` unchanged.
- 256 qualified rising edges -> `Evt_Count` wraps to 0.
- Assert `Reset` during CHK_HI (counter=2) -> all outputs 0 immediately; no `Rise` after release while `Din`=0.
